qmac_seq: RTL and testbench

QMAC_SEQ -- requirements
Module: qmac_seq

---
 rtl/qmac_seq.sv | 150 +++++++++++++++
 tb/tb_qmac_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qmac_seq.sv
// qmac_seq: sequential sign-magnitude Q-format multiply-accumulate.
// Each accepted operand pair goes to an external serial multiplier through a
// start/complete handshake. The product is then added into a saturating
// sign-magnitude accumulator. The pair flagged last closes the vector: the
// result is published with a one-cycle valid pulse and the accumulator is
// cleared.
module qmac_seq #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_last,
   output logic         o_ready,
   output logic [N-1:0] o_mul_a,
   output logic [N-1:0] o_mul_b,
   output logic         o_mul_start,
   input  logic         i_mul_complete,
   input  logic [N-1:0] i_mul_result,
   input  logic         i_mul_overflow,
   output logic [N-1:0] o_acc,
   output logic         o_acc_valid,
   output logic         o_overflow
);

   // The accumulator does not depend on Q. Q only fixes where the binary
   // point sits, and it must leave at least one integer bit.
   if (Q >= N - 1) begin : g_q_range
      $error("qmac_seq: Q must be smaller than N-1");
   end

   typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, ACC, DONE} state_t;

   state_t         state;
   logic           last;
   logic           prod_sign;
   logic [N-2:0]   prod_mag;
   logic           prod_ovf;
   logic           acc_sign;
   logic [N-2:0]   acc_mag;
   logic           vflag;

   logic           p_sign;
   logic [N-1:0]   sum_wide;
   logic [N-2:0]   diff_ap;
   logic [N-2:0]   diff_pa;
   logic           nxt_sign;
   logic [N-2:0]   nxt_mag;
   logic           nxt_sat;

   assign o_ready = (state == IDLE);

   // Sign-magnitude add of the captured product into the accumulator.
   // A -0 product is folded to +0, and any zero result is forced positive.
   always_comb begin
      nxt_sign = 1'b0;
      nxt_mag  = '0;
      nxt_sat  = 1'b0;
      p_sign   = prod_sign & (|prod_mag);
      sum_wide = {1'b0, acc_mag} + {1'b0, prod_mag};
      diff_ap  = acc_mag - prod_mag;
      diff_pa  = prod_mag - acc_mag;
      if (p_sign == acc_sign) begin
         nxt_sign = acc_sign;
         if (sum_wide[N-1]) begin
            nxt_mag = '1;
            nxt_sat = 1'b1;
         end else begin
            nxt_mag = sum_wide[N-2:0];
         end
      end else if (acc_mag >= prod_mag) begin
         nxt_sign = acc_sign;
         nxt_mag  = diff_ap;
      end else begin
         nxt_sign = p_sign;
         nxt_mag  = diff_pa;
      end
      if (nxt_mag == '0) nxt_sign = 1'b0;
   end

   // Control FSM with registered multiplier and result outputs.
   // WAIT_LOW must see complete drop before WAIT_HIGH, because the complete
   // flag is still high from the previous product right after the start pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         last        <= 1'b0;
         o_mul_a     <= '0;
         o_mul_b     <= '0;
         o_mul_start <= 1'b0;
         prod_sign   <= 1'b0;
         prod_mag    <= '0;
         prod_ovf    <= 1'b0;
         acc_sign    <= 1'b0;
         acc_mag     <= '0;
         vflag       <= 1'b0;
         o_acc       <= '0;
         o_acc_valid <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         o_acc_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_valid) begin
                  o_mul_a     <= i_a;
                  o_mul_b     <= i_b;
                  last        <= i_last;
                  o_mul_start <= 1'b1;
                  state       <= START;
               end
            end
            START: begin
               o_mul_start <= 1'b0;
               state       <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!i_mul_complete) state <= WAIT_HIGH;
            end
            WAIT_HIGH: begin
               if (i_mul_complete) begin
                  prod_sign <= i_mul_result[N-1];
                  prod_mag  <= i_mul_result[N-2:0];
                  prod_ovf  <= i_mul_overflow;
                  state     <= ACC;
               end
            end
            ACC: begin
               acc_sign <= nxt_sign;
               acc_mag  <= nxt_mag;
               vflag    <= vflag | prod_ovf | nxt_sat;
               state    <= last ? DONE : IDLE;
            end
            DONE: begin
               o_acc       <= {acc_sign, acc_mag};
               o_overflow  <= vflag;
               o_acc_valid <= 1'b1;
               acc_sign    <= 1'b0;
               acc_mag     <= '0;
               vflag       <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qmac_seq.sv
// Testbench for qmac_seq: a multiplier stub with programmable hold/busy
// timing, and an integer-arithmetic reference model of the dot product.
module tb_qmac_seq;
   localparam int     Q    = 15;
   localparam int     N    = 32;
   localparam longint MAXM = 64'h7FFFFFFF;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         i_last = 1'b0;
   logic [N-1:0] i_a = '0;
   logic [N-1:0] i_b = '0;
   logic         o_ready, o_mul_start, o_acc_valid, o_overflow;
   logic [N-1:0] o_mul_a, o_mul_b, o_acc;
   logic         mul_complete = 1'b1;
   logic         mul_ovf = 1'b0;
   logic [N-1:0] mul_result = '0;

   int           m_hold = 0;
   int           m_busy = 2;
   bit           force_en = 1'b0;
   logic [N-1:0] force_val = '0;
   bit           m_act = 1'b0;
   int           m_t = 0;
   logic [N:0]   m_pend = '0;

   int           total = 0;
   int           bad = 0;
   int           vcount = 0;
   int           scount = 0;
   longint       acc_v = 0;
   bit           acc_ovf = 1'b0;
   logic [N-1:0] prev_acc = '0;
   logic [N-1:0] got_acc = '0;
   logic         got_ovf = 1'b0;
   logic [N-1:0] va [8];
   logic [N-1:0] vb [8];

   always #5 i_clk = ~i_clk;

   qmac_seq #(.Q(Q), .N(N)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_a(i_a), .i_b(i_b),
      .i_last(i_last), .o_ready(o_ready), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
      .o_mul_start(o_mul_start), .i_mul_complete(mul_complete),
      .i_mul_result(mul_result), .i_mul_overflow(mul_ovf), .o_acc(o_acc),
      .o_acc_valid(o_acc_valid), .o_overflow(o_overflow)
   );

   // Q-format product with magnitude saturation; {overflow, result}.
   function automatic logic [N:0] mul_ref(input logic [N-1:0] a, input logic [N-1:0] b);
      longint unsigned m;
      if (force_en) return {1'b0, force_val};
      m = (64'(a[N-2:0]) * 64'(b[N-2:0])) >> Q;
      if (m > 64'(MAXM)) return {1'b1, a[N-1] ^ b[N-1], {(N-1){1'b1}}};
      return {1'b0, a[N-1] ^ b[N-1], m[N-2:0]};
   endfunction

   function automatic logic [N-1:0] enc(input longint v);
      if (v < 0) return {1'b1, (N-1)'(-v)};
      return {1'b0, (N-1)'(v)};
   endfunction

   // Multiplier stub: complete stays high for m_hold cycles after start,
   // then low for m_busy cycles, then rises with the new product.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         m_act = 1'b0;
         mul_complete = 1'b1;
      end else begin
         if (!m_act && o_mul_start) begin
            m_act = 1'b1;
            m_t = 0;
            m_pend = mul_ref(o_mul_a, o_mul_b);
         end
         if (m_act) begin
            if (m_t == m_hold) mul_complete = 1'b0;
            if (m_t == m_hold + m_busy) begin
               mul_complete = 1'b1;
               mul_result = m_pend[N-1:0];
               mul_ovf = m_pend[N];
               m_act = 1'b0;
            end
            m_t++;
         end
      end
   end

   // Count start and result pulses at the active edge.
   always @(posedge i_clk) begin
      if (o_acc_valid) vcount++;
      if (o_mul_start) scount++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_add(input logic [N:0] pr);
      longint p;
      p = longint'(pr[N-2:0]);
      if (pr[N-1]) p = -p;
      acc_v = acc_v + p;
      if (acc_v > MAXM) begin acc_v = MAXM; acc_ovf = 1'b1; end
      if (acc_v < -MAXM) begin acc_v = -MAXM; acc_ovf = 1'b1; end
      if (pr[N]) acc_ovf = 1'b1;
   endtask

   task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b, input logic lst);
      int k;
      k = 0;
      @(negedge i_clk);
      while (!o_ready && k < 500) begin @(negedge i_clk); k++; end
      if (!o_ready) chk("ready_timeout", 64'(o_ready), 64'd1);
      i_valid = 1'b1; i_a = a; i_b = b; i_last = lst;
      @(negedge i_clk);
      chk("mul_a", 64'(o_mul_a), 64'(a));
      chk("mul_b", 64'(o_mul_b), 64'(b));
      chk("mul_start", 64'(o_mul_start), 64'd1);
      chk("acc_hold", 64'(o_acc), 64'(prev_acc));
      // junk while busy must be ignored
      i_a = $urandom; i_b = $urandom; i_last = 1'($urandom);
      @(negedge i_clk);
      i_valid = 1'b0;
      model_add(mul_ref(a, b));
   endtask

   task automatic run_vec(input int n, input string tag);
      int s0, v0, k;
      bit rdy;
      s0 = scount; v0 = vcount; k = 0; rdy = 1'b0;
      for (int i = 0; i < n; i++) send_pair(va[i], vb[i], i == n - 1);
      while (!o_acc_valid && k < 500) begin rdy |= o_ready; @(negedge i_clk); k++; end
      chk({tag, "_valid"}, 64'(o_acc_valid), 64'd1);
      chk({tag, "_ready_low"}, 64'(rdy), 64'd0);
      got_acc = o_acc; got_ovf = o_overflow;
      chk({tag, "_acc"}, 64'(o_acc), 64'(enc(acc_v)));
      chk({tag, "_ovf"}, 64'(o_overflow), 64'(acc_ovf));
      prev_acc = enc(acc_v);
      acc_v = 0; acc_ovf = 1'b0;
      @(negedge i_clk);
      chk({tag, "_pulse1"}, 64'(o_acc_valid), 64'd0);
      chk({tag, "_starts"}, 64'(scount - s0), 64'(n));
      chk({tag, "_vcount"}, 64'(vcount - v0), 64'd1);
   endtask

   function automatic logic [N-1:0] rnd_op();
      int sel;
      logic s;
      sel = $urandom_range(0, 9);
      s = 1'($urandom);
      if (sel == 0) return {s, {(N-1){1'b0}}};
      if (sel == 1) return {s, (N-1)'($urandom)};
      return {s, (N-1)'($urandom_range(0, 32'h60000))};
   endfunction

   initial begin
      int v0, n;
      // reset state
      #3;
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_start", 64'(o_mul_start), 64'd0);
      chk("rst_acc", 64'(o_acc), 64'd0);
      chk("rst_valid", 64'(o_acc_valid), 64'd0);
      chk("rst_ovf", 64'(o_overflow), 64'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;

      // single pair: 1.5 * 2.0 = 3.0
      va[0] = 32'h0000C000; vb[0] = 32'h00010000;
      run_vec(1, "single");
      chk("single_const", 64'(got_acc), 64'h00018000);
      chk("single_ovf0", 64'(got_ovf), 64'd0);

      // cancellation to +0
      va[0] = 32'h00008000; vb[0] = 32'h00018000;
      va[1] = 32'h80008000; vb[1] = 32'h00018000;
      run_vec(2, "cancel");
      chk("cancel_const", 64'(got_acc), 64'h00000000);

      // result takes sign of larger magnitude: 2.0 - 3.0 = -1.0
      va[0] = 32'h00010000; vb[0] = 32'h00008000;
      va[1] = 32'h80008000; vb[1] = 32'h00018000;
      run_vec(2, "sign");
      chk("sign_const", 64'(got_acc), 64'h80008000);

      // saturation, then the next vector starts with a clear flag
      force_en = 1'b1; force_val = 32'h7FFF0000;
      va[0] = 32'h00008000; vb[0] = 32'h00008000;
      va[1] = 32'h00008000; vb[1] = 32'h00008000;
      run_vec(2, "sat");
      chk("sat_const", 64'(got_acc), 64'h7FFFFFFF);
      chk("sat_ovf1", 64'(got_ovf), 64'd1);
      force_en = 1'b0;
      va[0] = 32'h00008000; vb[0] = 32'h00008000;
      run_vec(1, "after_sat");
      chk("after_sat_ovf0", 64'(got_ovf), 64'd0);

      // complete held high 3 cycles after start: 2.5 * -1.0 = -2.5
      m_hold = 3; m_busy = 3;
      va[0] = 32'h00014000; vb[0] = 32'h80008000;
      run_vec(1, "hshake");
      chk("hshake_const", 64'(got_acc), 64'h80014000);

      // reset while waiting in WAIT_HIGH, with a partial sum already held
      m_hold = 0; m_busy = 10;
      send_pair(32'h00010000, 32'h00010000, 1'b0);
      send_pair(32'h00008000, 32'h00018000, 1'b0);
      @(negedge i_clk);
      v0 = vcount;
      #2 i_rst_n = 1'b0;
      #1;
      chk("mrst_ready", 64'(o_ready), 64'd1);
      chk("mrst_start", 64'(o_mul_start), 64'd0);
      chk("mrst_mul_a", 64'(o_mul_a), 64'd0);
      chk("mrst_mul_b", 64'(o_mul_b), 64'd0);
      chk("mrst_acc", 64'(o_acc), 64'd0);
      chk("mrst_valid", 64'(o_acc_valid), 64'd0);
      chk("mrst_ovf", 64'(o_overflow), 64'd0);
      acc_v = 0; acc_ovf = 1'b0; prev_acc = '0;
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("mrst_no_valid", 64'(vcount - v0), 64'd0);
      m_busy = 2;
      // 3.0 * -0.5 = -1.5
      va[0] = 32'h00018000; vb[0] = 32'h80004000;
      run_vec(1, "post_rst");
      chk("post_rst_const", 64'(got_acc), 64'h8000C000);

      // randomized vectors against the model
      for (int v = 0; v < 12; v++) begin
         n = $urandom_range(1, 4);
         m_hold = $urandom_range(0, 2);
         m_busy = $urandom_range(2, 4);
         for (int i = 0; i < n; i++) begin
            va[i] = rnd_op();
            vb[i] = rnd_op();
         end
         run_vec(n, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
